// File: rtl/tt_gate_unit.sv
// tt_gate_unit: bitwise two-input function generator driven by a 4-bit truth
// table. Each result bit is tt indexed by the matching {a, b} bit pair, which
// covers all 16 two-input gates. Operands use a valid/ready handshake, and the
// single output register supports full-throughput back-to-back transfers.
// A small three-state engine self-tests a latched copy of the truth table. It
// compares a sum-of-products evaluation against a 4:1 mux evaluation, one
// minterm per cycle.
module tt_gate_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       tt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             selftest_start,
  output logic             selftest_busy,
  output logic             selftest_done,
  output logic             selftest_pass,
  output logic [2:0]       mismatch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Output stage (one register of latency).
  logic [WIDTH-1:0] r_s_p1;
  logic             r_vld_p1;

  // Self-test context.
  logic [3:0] r_tt_lat;
  logic [1:0] r_m;
  logic [2:0] r_mcnt;
  logic       r_pass;

  logic       w_accept;
  logic       w_in_ready;
  logic       w_start;
  logic       w_last;
  logic       w_mis;
  logic [2:0] w_mcnt_nxt;
  logic       w_busy;
  logic       w_done;
  logic [WIDTH-1:0] w_result;

  // Truth-table lookup as a plain 4:1 mux on the minterm index.
  function automatic logic f_mux_eval(input logic [3:0] t, input logic [1:0] m);
    return t[m];
  endfunction

  // Same lookup written as a sum of products over the decoded minterm.
  // It is structurally independent of the mux form, so the two can
  // cross-check each other.
  function automatic logic f_sop_eval(input logic [3:0] t, input logic [1:0] m);
    logic x;
    logic y;
    x = m[1];
    y = m[0];
    return (t[0] & ~x & ~y) |
           (t[1] & ~x &  y) |
           (t[2] &  x & ~y) |
           (t[3] &  x &  y);
  endfunction

  // Apply the truth table independently to every bit position.
  function automatic logic [WIDTH-1:0] f_apply(input logic [3:0]       t,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = f_mux_eval(t, {x[i], y[i]});
    end
    return r;
  endfunction

  // Handshake decode. A start request always blocks operands, so when a start
  // and an operand arrive together, the self-test wins. Reset forces
  // in_ready low.
  always_comb begin
    w_in_ready = 1'b0;
    if (!reset && (r_state == IDLE) && !selftest_start &&
        (!r_vld_p1 || out_ready)) begin
      w_in_ready = 1'b1;
    end
  end

  // Operand and self-test event decode.
  always_comb begin
    w_accept   = in_valid && w_in_ready;
    w_start    = (r_state == IDLE) && selftest_start && !r_vld_p1;
    w_last     = (r_m == 2'd3);
    w_mis      = f_sop_eval(r_tt_lat, r_m) != f_mux_eval(r_tt_lat, r_m);
    w_mcnt_nxt = r_mcnt + {2'b00, w_mis};
    w_result   = f_apply(tt, a, b);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. RUN walks minterms 0..3 and then visits DONE
  // for exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start) w_state_nxt = RUN;
      RUN:  if (w_last)  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers RUN and DONE; done marks the final cycle.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN: w_busy = 1'b1;
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // --- stage p0 -> p1: result register and its valid flag ---
  // A new result overwrites the old one on accept. Without an accept, a
  // drain empties the register. While stalled, s is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_s_p1   <= w_result;
      r_vld_p1 <= 1'b1;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Self-test context: latch tt at start so later tt changes are ignored.
  // Count mismatches per minterm, and settle pass on the last minterm so it
  // is valid during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tt_lat <= 4'd0;
      r_m      <= 2'd0;
      r_mcnt   <= 3'd0;
      r_pass   <= 1'b0;
    end else if (w_start) begin
      r_tt_lat <= tt;
      r_m      <= 2'd0;
      r_mcnt   <= 3'd0;
      r_pass   <= 1'b0;
    end else if (r_state == RUN) begin
      r_mcnt <= w_mcnt_nxt;
      r_m    <= r_m + 2'd1;
      if (w_last) begin
        r_pass <= (w_mcnt_nxt == 3'd0);
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign s              = r_s_p1;
  assign out_valid      = r_vld_p1;
  assign selftest_busy  = w_busy;
  assign selftest_done  = w_done;
  assign selftest_pass  = r_pass;
  assign mismatch_count = r_mcnt;

endmodule

// File: tb/tb_tt_gate_unit.sv
// Bench for tt_gate_unit: directed vectors with a cycle-level behavioural
// model and hand-computed literal expectations at key points.
module tb_tt_gate_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   tt;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic         out_valid;
  logic         out_ready;
  logic         selftest_start;
  logic         selftest_busy;
  logic         selftest_done;
  logic         selftest_pass;
  logic [2:0]   mismatch_count;

  int checks   = 0;
  int failures = 0;

  tt_gate_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .tt(tt), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .selftest_start(selftest_start), .selftest_busy(selftest_busy),
    .selftest_done(selftest_done), .selftest_pass(selftest_pass),
    .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: look up tt at index 2*a_bit + b_bit for each bit.
  function automatic int ref_gate(input int t, input int x, input int y);
    int r;
    r = 0;
    for (int i = 0; i < W; i++) begin
      int idx;
      idx = 2 * ((x >> i) & 1) + ((y >> i) & 1);
      r = r | (((t >> idx) & 1) << i);
    end
    return r;
  endfunction

  // Model state: result slot, plus a countdown of remaining busy cycles.
  int m_s = 0, m_ov = 0, m_left = 0, m_pass = 0, m_mcnt = 0;
  bit m_live = 0;

  function automatic int m_ready();
    return (!reset && m_left == 0 && !selftest_start && (!m_ov || out_ready)) ? 1 : 0;
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) begin
    int acc;
    acc = (in_valid && m_ready() != 0) ? 1 : 0;
    if (reset) begin
      m_s = 0; m_ov = 0; m_left = 0; m_pass = 0; m_mcnt = 0;
      m_live = 1;
    end else begin
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 1) m_pass = 1;  // mux and SOP of one table always agree
      end else if (selftest_start && !m_ov) begin
        m_left = 5; m_pass = 0; m_mcnt = 0;
      end
      if (acc != 0) begin
        m_s = ref_gate(tt, a, b); m_ov = 1;
      end else if (m_ov != 0 && out_ready) begin
        m_ov = 0;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, m_ready());
      chk("s", s, m_s);
      chk("out_valid", out_valid, m_ov);
      chk("busy", selftest_busy, (m_left > 0) ? 1 : 0);
      chk("done", selftest_done, (m_left == 1) ? 1 : 0);
      chk("pass", selftest_pass, m_pass);
      chk("mismatch_count", mismatch_count, m_mcnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] va [4] = '{4'b0000, 4'b1111, 4'b1010, 4'b1100};
  logic [3:0] vb [4] = '{4'b0000, 4'b0000, 4'b1010, 4'b1010};
  logic [3:0] vs [4] = '{4'b1111, 4'b0000, 4'b1111, 4'b1001};

  initial begin
    reset = 1; tt = 0; a = 0; b = 0; in_valid = 0; out_ready = 0; selftest_start = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("lit_reset_in_ready", in_ready, 0);
    chk("lit_reset_s", s, 0);
    chk("lit_reset_ovalid", out_valid, 0);
    cyc();
    reset = 0;

    // a'.b gate
    tt = 4'b0010; a = 4'b0011; b = 4'b0101; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("lit_andn_s", s, 4'b0100);
    chk("lit_andn_ovalid", out_valid, 1);
    cyc();

    // XNOR, then four back-to-back accepts
    tt = 4'b1001; a = 4'b0011; b = 4'b0101; in_valid = 1;
    cyc();
    @(negedge clk);
    chk("lit_xnor_s", s, 4'b1001);
    for (int k = 0; k < 4; k++) begin
      a = va[k]; b = vb[k];
      cyc();
      @(negedge clk);
      chk("lit_b2b_s", s, vs[k]);
      chk("lit_b2b_ovalid", out_valid, 1);
    end
    in_valid = 0;
    cyc();

    // Backpressure: hold for 3 cycles, then drain and accept together
    tt = 4'b0110; a = 4'b0011; b = 4'b0101; in_valid = 1; out_ready = 0;
    cyc();
    a = 4'b1111; b = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_stall_s", s, 4'b0110);
      chk("lit_stall_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    chk("lit_drain_in_ready", in_ready, 1);
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("lit_drain_s", s, 4'b1110);
    cyc();

    // Start while a result is pending is ignored
    in_valid = 1; out_ready = 0; a = 4'b0001; b = 4'b0001;
    cyc();
    in_valid = 0; selftest_start = 1;
    cyc();
    selftest_start = 0;
    @(negedge clk);
    chk("lit_ignored_start_busy", selftest_busy, 0);
    out_ready = 1;
    cyc();

    // Self-test timing; tt changes mid-run have no effect
    tt = 4'b0110; selftest_start = 1;
    cyc();
    selftest_start = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) tt = 4'b1111;
      @(negedge clk);
      chk("lit_st_busy", selftest_busy, (c <= 5) ? 1 : 0);
      chk("lit_st_done", selftest_done, (c == 5) ? 1 : 0);
      if (c == 5) begin
        chk("lit_st_pass", selftest_pass, 1);
        chk("lit_st_mcnt", mismatch_count, 0);
      end
      cyc();
    end

    // Start and operand together: self-test wins
    tt = 4'b1000; a = 4'b1100; b = 4'b1010; in_valid = 1; selftest_start = 1;
    @(negedge clk);
    chk("lit_prio_in_ready", in_ready, 0);
    cyc();
    selftest_start = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("lit_prio_ready_seq", in_ready, (c == 6) ? 1 : 0);
      cyc();
    end
    in_valid = 0;
    @(negedge clk);
    chk("lit_prio_s", s, 4'b1000);
    cyc();

    // Reset aborts a running self-test
    selftest_start = 1;
    cyc();
    selftest_start = 0;
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    @(negedge clk);
    chk("lit_abort_busy", selftest_busy, 0);
    chk("lit_abort_done", selftest_done, 0);
    chk("lit_abort_ovalid", out_valid, 0);
    chk("lit_abort_s", s, 0);
    chk("lit_abort_pass", selftest_pass, 0);
    for (int c = 0; c < 6; c++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_gate_unit.md
TT_GATE_UNIT -- requirements
Module: tt_gate_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tt  input  4  truth table; tt[m] is the output for minterm m = {a_bit, b_bit} (m0=00, m1=01, m2=10, m3=11).
REQ-005 a, b  input  WIDTH each  operands.
REQ-006 in_valid  input  1  operand/tt offer.
REQ-007 in_ready  output  1  unit accepts the offer this cycle.
REQ-008 s  output  WIDTH  registered result.
REQ-009 out_valid  output  1  s holds an undelivered result.
REQ-010 out_ready  input  1  consumer takes s this cycle.
REQ-011 selftest_start  input  1  request a truth-table self-test of the current tt.
REQ-012 selftest_busy  output  1  self-test in progress.
REQ-013 selftest_done  output  1  one-cycle pulse at self-test end.
REQ-014 selftest_pass  output  1  result of the last completed self-test.
REQ-015 mismatch_count  output  3  minterms failed in the last self-test, 0..4.

Function
REQ-016 Per bit i: s[i] = tt[{a[i], b[i]}]; e.g. tt=4'b0010 gives a'.b, tt=4'b1001 gives XNOR.
REQ-017 in_ready = (state==IDLE) && !selftest_start && (!out_valid || out_ready).
REQ-018 Accept = in_valid && in_ready; on accept, a, b and tt are sampled together and s is loaded at the same edge (latency 1 cycle).
REQ-019 out_valid sets on accept; clears on out_valid && out_ready with no accept in the same cycle; stays 1 on simultaneous accept+drain (back-to-back, full throughput).
REQ-020 While out_valid=1 and out_ready=0, s is held stable and in_ready=0.
REQ-021 FSM states: IDLE, RUN, DONE.
REQ-022 IDLE->RUN when selftest_start=1 and out_valid=0; tt latched internally, minterm counter m=0 and mismatch_count=0 at that edge; start with out_valid=1 is ignored (no latch, no retry).
REQ-023 Simultaneous selftest_start and in_valid in IDLE: self-test has priority; operand not accepted (in_ready=0).
REQ-024 RUN: one minterm per cycle, m=0,1,2,3; each cycle compares a sum-of-products evaluation of latched tt at m against a 4:1 mux evaluation of latched tt at m; on inequality mismatch_count increments.
REQ-025 RUN->DONE after m=3 evaluated; m does not wrap inside RUN.
REQ-026 DONE lasts exactly one cycle: selftest_done=1, selftest_pass=(mismatch_count==0); then DONE->IDLE.
REQ-027 selftest_busy=1 in RUN and DONE; in_ready=0 and selftest_start ignored in those states.
REQ-028 selftest_pass and mismatch_count hold their values until the next self-test begins.
REQ-029 Changes to the tt input during RUN do not affect the self-test.

Reset
REQ-030 reset=1 at a clock edge: state=IDLE, s=0, out_valid=0, selftest_busy=0, selftest_done=0, selftest_pass=0, mismatch_count=0, m=0.
REQ-031 reset overrides all other inputs in the same cycle; reset during RUN aborts with no selftest_done pulse.
REQ-032 in_ready=0 while reset=1; it may rise in the first cycle after reset is released.

Verification
REQ-033 WIDTH=4, tt=4'b0010, a=4'b0011, b=4'b0101, in_valid=1, out_ready=1 -> next cycle s=4'b0100, out_valid=1.
REQ-034 tt=4'b1001, a=4'b0011, b=4'b0101 -> s=4'b1001; then four back-to-back accepts with out_ready=1 -> four results on consecutive cycles.
REQ-035 out_ready=0 after a result, in_valid=1 with new operands -> in_ready=0, s unchanged for 3 cycles; out_ready=1 -> drain and accept in the same cycle, new s next cycle.
REQ-036 tt=4'b0110, selftest_start pulse in IDLE at cycle 0 -> busy cycles 1-5, selftest_done=1 at cycle 5 only, selftest_pass=1, mismatch_count=0.
REQ-037 Self-test started, reset=1 at cycle 2 -> all outputs 0 next cycle, no selftest_done pulse.
REQ-038 selftest_start and in_valid both high in IDLE -> self-test starts, operand not accepted, in_ready=0 until after DONE.
